// File: rtl/seq_comparator_if.sv
// rtl/seq_comparator_if.sv - request/result bundle for the multi-cycle magnitude comparator
interface seq_comparator_if #(
    parameter int WIDTH = 32,
    parameter int CW    = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             zero_mode;
    logic             busy;
    logic             done;
    logic             eq;
    logic             less;
    logic             upper;
    logic [CW-1:0]    cycles;

    modport master (
        output start, a, b, signed_mode, zero_mode,
        input  busy, done, eq, less, upper, cycles
    );

    modport slave (
        input  start, a, b, signed_mode, zero_mode,
        output busy, done, eq, less, upper, cycles
    );
endinterface

// File: rtl/seq_comparator.sv
// rtl/seq_comparator.sv - MSB-first digit-serial magnitude comparator with start/busy/done handshake
module seq_comparator #(
    parameter int WIDTH      = 32,
    parameter int DIGIT      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    seq_comparator_if.slave  bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int CW   = $clog2(NDIG + 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             rec_lt_q, rec_lt_d;
    logic             rec_gt_q, rec_gt_d;
    logic             eq_q, eq_d;
    logic             less_q, less_d;
    logic             upper_q, upper_d;
    logic             done_q, done_d;
    logic [CW-1:0]    cycles_q, cycles_d;

    logic [DIGIT-1:0] dig_a, dig_b;
    logic             diff, first, new_lt, new_gt, fin;

    assign dig_a = op_a_q[(NDIG - 1 - int'(idx_q)) * DIGIT +: DIGIT];
    assign dig_b = op_b_q[(NDIG - 1 - int'(idx_q)) * DIGIT +: DIGIT];

    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        idx_d    = idx_q;
        rec_lt_d = rec_lt_q;
        rec_gt_d = rec_gt_q;
        eq_d     = eq_q;
        less_d   = less_q;
        upper_d  = upper_q;
        cycles_d = cycles_q;
        done_d   = 1'b0;
        diff     = (dig_a != dig_b);
        first    = diff && !rec_lt_q && !rec_gt_q;
        new_lt   = rec_lt_q || (first && (dig_a < dig_b));
        new_gt   = rec_gt_q || (first && (dig_a > dig_b));
        fin      = ((EARLY_EXIT != 0) && diff) || (idx_q == IW'(NDIG - 1));

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_a_d = bus.a;
                    op_b_d = bus.zero_mode ? '0 : bus.b;
                    // Biasing the sign bit turns a two's-complement compare into an unsigned one.
                    if (bus.signed_mode) begin
                        op_a_d[WIDTH-1] = ~op_a_d[WIDTH-1];
                        op_b_d[WIDTH-1] = ~op_b_d[WIDTH-1];
                    end
                    eq_d     = 1'b0;
                    less_d   = 1'b0;
                    upper_d  = 1'b0;
                    rec_lt_d = 1'b0;
                    rec_gt_d = 1'b0;
                    idx_d    = '0;
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                rec_lt_d = new_lt;
                rec_gt_d = new_gt;
                if (fin) begin
                    eq_d     = !new_lt && !new_gt;
                    less_d   = new_lt;
                    upper_d  = new_gt;
                    cycles_d = CW'(idx_q) + CW'(1);
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            idx_q    <= '0;
            rec_lt_q <= 1'b0;
            rec_gt_q <= 1'b0;
            eq_q     <= 1'b0;
            less_q   <= 1'b0;
            upper_q  <= 1'b0;
            done_q   <= 1'b0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            idx_q    <= idx_d;
            rec_lt_q <= rec_lt_d;
            rec_gt_q <= rec_gt_d;
            eq_q     <= eq_d;
            less_q   <= less_d;
            upper_q  <= upper_d;
            done_q   <= done_d;
            cycles_q <= cycles_d;
        end
    end

    assign bus.busy   = (state_q == SCAN);
    assign bus.done   = done_q;
    assign bus.eq     = eq_q;
    assign bus.less   = less_q;
    assign bus.upper  = upper_q;
    assign bus.cycles = cycles_q;
endmodule
